fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for a FIFO RAM with a two-cycle read
// latency. It issues reads from a wrapping address counter and stages the
// returned words in a 4-entry output queue with a valid/ready interface.
// Optional macro FIFO_RD_CTRL_STATS_EN adds a saturating 16-bit pop counter
// on output words_read.
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int RAM_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  rd_cs,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] address_to_read,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy
`ifdef FIFO_RD_CTRL_STATS_EN
   ,
   output logic [15:0]           words_read
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam int                    QDEPTH    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
   logic                    v1_q, v2_q;

   logic [DATA_WIDTH-1:0]   mem_q [QDEPTH];
   logic [1:0]              head_q, head_d;
   logic [1:0]              tail_q, tail_d;
   logic [2:0]              occ_q, occ_d;

   logic                    pop;
   logic                    capture;
   logic [2:0]              inflight;
   logic [3:0]              outstanding;
   logic                    issue;

   // A read is in flight from the cycle rd_en is high until its data lands
   // in the queue; v1/v2 follow rd_en so v2 marks the cycle fifo_data is valid.
   assign pop      = (occ_q != 3'd0) && m_ready;
   assign capture  = v2_q;
   assign inflight = {2'b00, rd_en_q} + {2'b00, v1_q} + {2'b00, v2_q};

   // Words already committed once this edge's pop is taken: queued plus in
   // flight. Crediting the pop keeps full throughput in steady streaming,
   // while the cap of 4 guarantees every returning word finds a free slot.
   assign outstanding = {1'b0, occ_q} + {1'b0, inflight} - {3'b000, pop};

   assign issue = (state_q == ST_RUN) && enable && !fifo_empty &&
                  (outstanding < 4'd4);

   assign rd_en           = rd_en_q;
   assign rd_cs           = rd_en_q;
   assign address_to_read = addr_q;
   assign m_valid         = (occ_q != 3'd0);
   assign m_data          = mem_q[head_q];
   assign busy            = (state_q != ST_IDLE);

   // FSM next state plus the registered read strobe and address for the next cycle.
   always_comb begin
      state_d     = state_q;
      rd_en_d     = 1'b0;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (inflight == 3'd0 && occ_q == 3'd0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (issue) begin
         rd_en_d     = 1'b1;
         addr_d      = next_addr_q;
         next_addr_d = (next_addr_q == LAST_ADDR) ? '0
                                                  : next_addr_q + ADDR_WIDTH'(1);
      end
   end

   // Queue pointer and occupancy bookkeeping; capture and pop may coincide.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (pop)     head_d = head_q + 2'd1;
      if (capture) tail_d = tail_q + 2'd1;
      case ({capture, pop})
         2'b10:   occ_d = occ_q + 3'd1;
         2'b01:   occ_d = occ_q - 3'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Control registers: FSM state, read strobe/address and the return-valid pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         next_addr_q <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         v1_q        <= rd_en_q;
         v2_q        <= v1_q;
      end
   end

   // Output queue storage and pointers; returning data is written at the tail.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (capture) mem_q[tail_q] <= fifo_data;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

`ifdef FIFO_RD_CTRL_STATS_EN
   logic [15:0] words_read_q;

   // Count accepted output words, holding at all-ones once saturated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words_read_q <= '0;
      end else if (pop && words_read_q != 16'hFFFF) begin
         words_read_q <= words_read_q + 16'd1;
      end
   end

   assign words_read = words_read_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized and directed stimulus for fifo_rd_ctrl, checked
// cycle by cycle against a transaction-level model (queues of outstanding
// reads and queued words). Build with FIFO_RD_CTRL_STATS_EN to cover words_read.
module tb_fifo_rd_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          enable     = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          m_ready    = 1'b0;
   logic [DW-1:0] fifo_data  = '0;
   logic          rd_cs;
   logic          rd_en;
   logic [AW-1:0] address_to_read;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          busy;
`ifdef FIFO_RD_CTRL_STATS_EN
   logic [15:0]   words_read;
`endif

   fifo_rd_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RAM_DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .rd_cs           (rd_cs),
      .rd_en           (rd_en),
      .address_to_read (address_to_read),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .busy            (busy)
`ifdef FIFO_RD_CTRL_STATS_EN
      ,
      .words_read      (words_read)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: each outstanding read remembers its data and issue cycle.
   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rd_t;

   rd_t           infl[$];
   logic [DW-1:0] outq[$];
   logic [DW-1:0] ram [DEPTH];
   int            st;          // 0 idle, 1 run, 2 stop
   int            nxt_addr;
   logic          exp_rd_en;
   int            exp_addr;
   int            cyc;
   int            pops;
   bit            quiet;

   // Behavioural FIFO RAM: two-cycle read latency, garbage otherwise.
   bit            a1_v, a2_v;
   logic [DW-1:0] a1_d, a2_d;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic compare_outputs();
      check("rd_en", 32'(rd_en), 32'(exp_rd_en));
      check("rd_cs", 32'(rd_cs), 32'(exp_rd_en));
      if (exp_rd_en) check("address", 32'(address_to_read), 32'(exp_addr));
      check("m_valid", 32'(m_valid), 32'(outq.size() != 0));
      if (outq.size() != 0) check("m_data", 32'(m_data), 32'(outq[0]));
      check("busy", 32'(busy), 32'(st != 0));
`ifdef FIFO_RD_CTRL_STATS_EN
      check("words_read", 32'(words_read), (pops > 65535) ? 32'hFFFF : 32'(pops));
`endif
   endtask

   // Advance the model across the coming edge using this cycle's inputs.
   task automatic model_step();
      int total;
      bit pop_now;
      bit issue;
      int nst;
      pop_now = (outq.size() != 0) && m_ready;
      total   = outq.size() + infl.size();
      issue   = (st == 1) && enable && !fifo_empty && ((total - int'(pop_now)) < 4);
      nst = st;
      case (st)
         0: if (enable) nst = 1;
         1: if (!enable) nst = 2;
         default: begin
            if (enable) nst = 1;
            else if (infl.size() == 0 && outq.size() == 0) nst = 0;
         end
      endcase
      if (pop_now) begin
         pops++;
         if (!quiet) $display("cycle %0d pop #%0d data=%04h", cyc, pops, outq[0]);
         void'(outq.pop_front());
      end
      if (infl.size() != 0 && infl[0].cyc == cyc - 2) begin
         outq.push_back(infl[0].data);
         void'(infl.pop_front());
      end
      if (issue) begin
         infl.push_back('{ram[nxt_addr], cyc + 1});
         exp_addr = nxt_addr;
         nxt_addr = (nxt_addr + 1) % DEPTH;
      end
      exp_rd_en = issue;
      st = nst;
   endtask

   task automatic run_cycle(input bit en, input bit emp, input bit rdy);
      enable     = en;
      fifo_empty = emp;
      m_ready    = rdy;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      fifo_data = a2_v ? a2_d : DW'($urandom);
      a2_v = a1_v;
      a2_d = a1_d;
      a1_v = rd_en;
      a1_d = ram[address_to_read];
      compare_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_rd_en",   32'(rd_en),           32'd0);
      check("rst_rd_cs",   32'(rd_cs),           32'd0);
      check("rst_address", 32'(address_to_read), 32'd0);
      check("rst_m_valid", 32'(m_valid),         32'd0);
      check("rst_m_data",  32'(m_data),          32'd0);
      check("rst_busy",    32'(busy),            32'd0);
`ifdef FIFO_RD_CTRL_STATS_EN
      check("rst_words_read", 32'(words_read),   32'd0);
`endif
      infl.delete();
      outq.delete();
      st        = 0;
      nxt_addr  = 0;
      exp_rd_en = 1'b0;
      exp_addr  = 0;
      pops      = 0;
      a1_v      = 1'b0;
      a2_v      = 1'b0;
      enable     = 1'b0;
      fifo_empty = 1'b1;
      m_ready    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      cyc += 2;
      rst = 1'b1;
      fifo_data = DW'($urandom);
   endtask

   initial begin
      cyc   = 0;
      quiet = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'(($urandom & 32'hFFF0) | i);
      #2;
      do_reset();

      // Continuous streaming: one read per cycle, addresses wrap past 15.
      repeat (24) run_cycle(1'b1, 1'b0, 1'b1);

      // Stalled sink: reads stop once 4 words are committed, then resume.
      repeat (10) run_cycle(1'b1, 1'b0, 1'b0);
      repeat (10) run_cycle(1'b1, 1'b0, 1'b1);

      // Empty FIFO while running: no reads, nothing valid, still busy.
      do_reset();
      repeat (10) run_cycle(1'b1, 1'b1, 1'b1);
      check("empty_run_busy", 32'(busy), 32'd1);

      // Drop enable with two reads in flight and one word queued.
      do_reset();
      repeat (4) run_cycle(1'b1, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b0);
      repeat (8) run_cycle(1'b0, 1'b0, 1'b1);
      check("stop_idle_busy", 32'(busy), 32'd0);

      // Reset while three words sit in the queue, then restart from address 0.
      repeat (4) run_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) run_cycle(1'b1, 1'b1, 1'b0);
      check("pre_rst_m_valid", 32'(m_valid), 32'd1);
      do_reset();
      repeat (8) run_cycle(1'b1, 1'b0, 1'b1);

      // Random traffic with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) != 0);
      end
      repeat (6) run_cycle(1'b0, 1'b0, 1'b1);

`ifdef FIFO_RD_CTRL_STATS_EN
      // Saturate the pop counter, then clear it with reset.
      do_reset();
      quiet = 1'b1;
      repeat (70010) run_cycle(1'b1, 1'b0, 1'b1);
      quiet = 1'b0;
      check("words_read_sat", 32'(words_read), 32'hFFFF);
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
